// File: rtl/board_reveal_ctrl.sv
// rtl/board_reveal_ctrl.sv - 5x5 board reveal controller: mine map, neighbour count, win/loss tracking
// Optional cell flagging is compiled in with BOARD_FLAG_EN.
module board_reveal_ctrl #(
  parameter int N_ROWS  = 5,
  parameter int N_COLS  = 5,
  parameter int N_CELLS = N_ROWS * N_COLS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_CELLS-1:0] mine_map,
  input  logic [4:0]         cell_idx,
  input  logic               cell_sel,
`ifdef BOARD_FLAG_EN
  input  logic               flag_sel,
  output logic [N_CELLS-1:0] flagged,
`endif
  output logic [N_CELLS-1:0] revealed,
  output logic [3:0]         adj_count,
  output logic               reveal_done,
  output logic               dup_sel,
  output logic [4:0]         revealed_count,
  output logic               game_won,
  output logic               game_lost,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_EVAL = 3'd2,
    S_WON  = 3'd3,
    S_LOST = 3'd4,
    S_FLAG = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [N_CELLS-1:0] mines_q, mines_d;
  logic [N_CELLS-1:0] revealed_q, revealed_d;
  logic [3:0]         adj_q, adj_d;
  logic [4:0]         rcount_q, rcount_d;
  logic [4:0]         safe_q, safe_d;
  logic [4:0]         pos_q, pos_d;
  logic               cell_sel_q, cell_sel_d;
  logic               done_q, done_d;
  logic               dup_q, dup_d;
  logic               req, idx_ok;
  logic [4:0]         pos_in;
`ifdef BOARD_FLAG_EN
  logic [N_CELLS-1:0] flagged_q, flagged_d;
  logic               flag_sel_q, flag_sel_d;
  logic               flag_req;
`endif

  // Neighbours are bounded by row and column separately so row ends never wrap.
  function automatic logic [3:0] count_adj(input logic [N_CELLS-1:0] map, input logic [4:0] pos);
    logic [3:0] cnt;
    logic [4:0] nb;
    int         r, c;
    cnt = '0;
    r   = int'(pos) / N_COLS;
    c   = int'(pos) % N_COLS;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < N_ROWS &&
            (c + dc) >= 0 && (c + dc) < N_COLS) begin
          nb = 5'((r + dr) * N_COLS + (c + dc));
          if (map[nb]) cnt = cnt + 4'd1;
        end
      end
    end
    return cnt;
  endfunction

  always_comb begin
    state_d    = state_q;
    mines_d    = mines_q;
    revealed_d = revealed_q;
    adj_d      = adj_q;
    rcount_d   = rcount_q;
    safe_d     = safe_q;
    pos_d      = pos_q;
    done_d     = 1'b0;
    dup_d      = 1'b0;
    cell_sel_d = cell_sel;
    req        = cell_sel & ~cell_sel_q;
    idx_ok     = (cell_idx >= 5'd1) && (int'(cell_idx) <= N_CELLS);
    pos_in     = cell_idx - 5'd1;
`ifdef BOARD_FLAG_EN
    flagged_d  = flagged_q;
    flag_sel_d = flag_sel;
    flag_req   = flag_sel & ~flag_sel_q;
`endif

    if (start) begin
      mines_d    = mine_map;
      revealed_d = '0;
      rcount_d   = '0;
      adj_d      = '0;
      safe_d     = 5'(N_CELLS - $countones(mine_map));
      state_d    = (safe_d == 5'd0) ? S_WON : S_PLAY;
`ifdef BOARD_FLAG_EN
      flagged_d  = '0;
`endif
    end else begin
      case (state_q)
        S_PLAY: begin
          if (req && idx_ok) begin
`ifdef BOARD_FLAG_EN
            if (!flagged_q[pos_in]) begin
              pos_d   = pos_in;
              state_d = S_EVAL;
            end
`else
            pos_d   = pos_in;
            state_d = S_EVAL;
`endif
          end
`ifdef BOARD_FLAG_EN
          else if (flag_req && idx_ok && !revealed_q[pos_in]) begin
            pos_d   = pos_in;
            state_d = S_FLAG;
          end
`endif
        end
        S_EVAL: begin
          if (revealed_q[pos_q]) begin
            dup_d   = 1'b1;
            state_d = S_PLAY;
          end else if (mines_q[pos_q]) begin
            revealed_d[pos_q] = 1'b1;
            done_d            = 1'b1;
            state_d           = S_LOST;
          end else begin
            revealed_d[pos_q] = 1'b1;
            rcount_d          = rcount_q + 5'd1;
            adj_d             = count_adj(mines_q, pos_q);
            done_d            = 1'b1;
            state_d           = (rcount_d == safe_q) ? S_WON : S_PLAY;
          end
        end
`ifdef BOARD_FLAG_EN
        S_FLAG: begin
          flagged_d[pos_q] = ~flagged_q[pos_q];
          state_d          = S_PLAY;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mines_q    <= '0;
      revealed_q <= '0;
      adj_q      <= '0;
      rcount_q   <= '0;
      safe_q     <= '0;
      pos_q      <= '0;
      cell_sel_q <= 1'b0;
      done_q     <= 1'b0;
      dup_q      <= 1'b0;
`ifdef BOARD_FLAG_EN
      flagged_q  <= '0;
      flag_sel_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mines_q    <= mines_d;
      revealed_q <= revealed_d;
      adj_q      <= adj_d;
      rcount_q   <= rcount_d;
      safe_q     <= safe_d;
      pos_q      <= pos_d;
      cell_sel_q <= cell_sel_d;
      done_q     <= done_d;
      dup_q      <= dup_d;
`ifdef BOARD_FLAG_EN
      flagged_q  <= flagged_d;
      flag_sel_q <= flag_sel_d;
`endif
    end
  end

  assign revealed       = revealed_q;
  assign adj_count      = adj_q;
  assign reveal_done    = done_q;
  assign dup_sel        = dup_q;
  assign revealed_count = rcount_q;
  assign game_won       = (state_q == S_WON);
  assign game_lost      = (state_q == S_LOST);
  assign state_o        = state_q;
`ifdef BOARD_FLAG_EN
  assign flagged        = flagged_q;
`endif

endmodule

// File: doc/board_reveal_ctrl.md
Name: board_reveal_ctrl

Overview:
Game-board controller sitting directly downstream of the 5x5 cell selector. It consumes the selector's 5-bit cell index (1..25) and its selected flag, reveals the chosen cell against a mine map loaded at game start, and computes the neighbouring-mine count for that cell. It tracks revealed cells and detects win or loss, feeding the display and game-status logic.

Parameters:
- N_ROWS, 5, board rows (fixed 5x5 board; other values unsupported)
- N_COLS, 5, board columns
- N_CELLS, 25, N_ROWS*N_COLS; cell index range is 1..N_CELLS

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  single-cycle pulse: load mine_map and begin a new game
- mine_map  in  25  bit k-1 = 1 means cell k holds a mine; sampled only on start
- cell_idx  in  5  selected cell index from the selector, 1..25
- cell_sel  in  1  selector "isSelected" level; its rising edge is a reveal request
- revealed  out  25  bit k-1 = 1 means cell k is revealed
- adj_count  out  4  mine count in the 8-neighbourhood of the last revealed cell, 0..8
- reveal_done  out  1  one-cycle pulse when a reveal completes
- dup_sel  out  1  one-cycle pulse when the request targets an already-revealed cell
- revealed_count  out  5  number of revealed safe cells
- game_won  out  1  level, high in WON
- game_lost  out  1  level, high in LOST
- state_o  out  3  current FSM state encoding, for debug

Behaviour:
- Reset (rst=0, async): state IDLE; revealed=0, adj_count=0, revealed_count=0, all pulses 0, game_won=0, game_lost=0, internal mine register=0, edge-detect register=0.
- Cell mapping: idx k maps to bit k-1, row=(k-1)/5, col=(k-1)%5. Neighbours outside rows 0..4 or cols 0..4 are excluded; there is no wrap-around across row ends.
- Edge detect: req = cell_sel & ~cell_sel_q. The register cell_sel_q updates every cycle in every state.
- FSM states: IDLE, PLAY, EVAL, WON, LOST.
- IDLE: waits for start.
- start, in any state: next cycle the block registers mine_map, clears revealed, revealed_count and adj_count, and computes safe_total = 25 - popcount(mine_map). It goes to PLAY, or to WON if safe_total == 0. start has priority over a same-cycle req.
- PLAY, on req with cell_idx in 1..25: latch the index and go to EVAL. A req with idx 0 or 26..31 is ignored, with no pulse.
- EVAL (1 cycle), if the cell is already revealed: dup_sel=1, no other change, return to PLAY.
- EVAL, if the cell holds a mine: set its revealed bit and go to LOST. revealed_count is unchanged. reveal_done=1. adj_count holds its previous value.
- EVAL, if the cell is safe: set its revealed bit, revealed_count+1, adj_count = neighbour mine count, reveal_done=1. Go to WON if the new count == safe_total, else PLAY.
- Latency: request edge at cycle t, results visible after clock edge t+2; outputs are registered.
- A req outside PLAY (EVAL, WON, LOST, IDLE) is dropped, not queued.
- WON/LOST: terminal; only start or reset exits. game_won/game_lost are asserted from the cycle the state is entered.
- Reset asserted mid-EVAL aborts immediately to the reset values; a partially completed reveal is not applied.

Optional Feature:
- Macro: BOARD_FLAG_EN.
- Defined: adds input flag_sel (1) and output flagged (25).
  - Rising edge of flag_sel in PLAY toggles flagged[cell_idx-1] in a 1-cycle FLAG state, but only if that cell is unrevealed.
  - A reveal request on a flagged cell is ignored: no pulses, no state change.
  - start and reset clear flagged.
  - If cell_sel and flag_sel rise in the same cycle, the reveal wins.
- Undefined: no flag ports, no FLAG state; behaviour exactly as above.

Test Plan:
- Reset, then start with mine_map=25'h0000001 (mine at cell 1); reveal cell 7 -> reveal_done at t+2, adj_count=1, revealed[6]=1, revealed_count=1, state PLAY.
- Same map; reveal cell 1 -> revealed[0]=1, game_lost=1, revealed_count stays 0; a later req on cell 2 is dropped.
- Map with mines at cells 5 and 6; reveal cell 10 -> adj_count=1, not 2. This proves no row wrap, since cell 6 is not a neighbour of cell 10.
- Map = all mines except cell 13; reveal 13 -> adj_count=8, game_won=1. Then start with mine_map=25'h1FFFFFF -> WON immediately, revealed_count=0.
- Reveal cell 3 twice (cell_sel falls and rises again) -> second request gives dup_sel=1, revealed_count unchanged. Holding cell_sel high for 10 cycles produces only one request.
- Pull rst low during EVAL -> all outputs reset asynchronously. Also: cell_idx=0 with a cell_sel edge -> no pulse, state PLAY.
